// File: rtl/seq_slice_adder_pkg.sv
// Shared definitions for the sequential slice adder.
//   state_t  : controller states (IDLE, RUN, DONE)
//   MODE_*   : encoding of the sub input
//   clog2    : counter width helper, never narrower than one bit
package seq_slice_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // ceil(log2(value)) with a floor of 1 so a single-slice build still
  // gets a legal one-bit index register.
  function automatic int clog2(input int value);
    int bits;
    bits = 1;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/slice_adder.sv
// Combinational SLICE-bit ripple-carry adder.
//   a_s, b_s : slice operands
//   c_in     : carry into bit 0
//   s        : slice sum
//   c_out    : carry out of the slice MSB
//   c_msb_in : carry into the slice MSB (feeds signed-overflow detection)
module slice_adder #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_s,
  input  logic [SLICE-1:0] b_s,
  input  logic             c_in,
  output logic [SLICE-1:0] s,
  output logic             c_out,
  output logic             c_msb_in
);

  logic [SLICE:0] carry;

  assign carry[0] = c_in;

  for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
    assign s[gi]        = a_s[gi] ^ b_s[gi] ^ carry[gi];
    assign carry[gi+1]  = (a_s[gi] & b_s[gi]) | (carry[gi] & (a_s[gi] ^ b_s[gi]));
  end

  assign c_out    = carry[SLICE];
  assign c_msb_in = carry[SLICE-1];

endmodule

// File: rtl/seq_slice_adder.sv
// Multi-cycle adder/subtractor: one SLICE-bit ripple slice per clock,
// inter-slice carry held in a register, valid/ready on both sides.
//   clk, rst_n            : clock (rising edge), async active-low reset
//   in_valid / in_ready   : operand handshake
//   a, b, cin, sub        : operands; cin used in ADD mode only
//   out_valid / out_ready : result handshake
//   sum, cout, ovf        : result, MSB carry-out, signed overflow
module seq_slice_adder #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  import seq_slice_adder_pkg::*;

  localparam int NUM_SLICES = WIDTH / SLICE;
  localparam int IDX_W      = clog2(NUM_SLICES);

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   a_reg, a_next;
  logic [WIDTH-1:0]   b_reg, b_next;     // already inverted in SUB mode
  logic               carry_reg, carry_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [WIDTH-1:0]   sum_reg, sum_next;
  logic               cout_reg, cout_next;
  logic               ovf_reg, ovf_next;

  logic [SLICE-1:0]   a_slices [NUM_SLICES];
  logic [SLICE-1:0]   b_slices [NUM_SLICES];
  logic [SLICE-1:0]   a_s, b_s, s_s;
  logic               c_out_s, c_msb_s;
  logic               last_slice;

  for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_view
    assign a_slices[gi] = a_reg[gi*SLICE +: SLICE];
    assign b_slices[gi] = b_reg[gi*SLICE +: SLICE];
  end

  // Slice selection by idx; a compare-per-slice mux keeps every build
  // (including non-power-of-two slice counts) free of out-of-range reads.
  always_comb begin
    a_s = '0;
    b_s = '0;
    for (int i = 0; i < NUM_SLICES; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        a_s = a_slices[i];
        b_s = b_slices[i];
      end
    end
  end

  slice_adder #(.SLICE(SLICE)) u_slice (
    .a_s      (a_s),
    .b_s      (b_s),
    .c_in     (carry_reg),
    .s        (s_s),
    .c_out    (c_out_s),
    .c_msb_in (c_msb_s)
  );

  assign last_slice = (idx_reg == IDX_W'(NUM_SLICES - 1));

  assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
  assign out_valid = (state_reg == DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      carry_reg <= carry_next;
      idx_reg   <= idx_next;
      sum_reg   <= sum_next;
      cout_reg  <= cout_next;
      ovf_reg   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    carry_next = carry_reg;
    idx_next   = idx_reg;
    sum_next   = sum_reg;
    cout_next  = cout_reg;
    ovf_next   = ovf_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          a_next     = a;
          b_next     = (sub == MODE_SUB) ? ~b : b;
          carry_next = (sub == MODE_SUB) ? 1'b1 : cin;
          idx_next   = '0;
          state_next = RUN;
        end
      end

      RUN: begin
        for (int i = 0; i < NUM_SLICES; i++) begin
          if (idx_reg == IDX_W'(i)) sum_next[i*SLICE +: SLICE] = s_s;
        end
        carry_next = c_out_s;
        idx_next   = idx_reg + IDX_W'(1);
        if (last_slice) begin
          cout_next  = c_out_s;
          ovf_next   = c_msb_s ^ c_out_s;
          state_next = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            // Result handshake and new operand share this edge.
            a_next     = a;
            b_next     = (sub == MODE_SUB) ? ~b : b;
            carry_next = (sub == MODE_SUB) ? 1'b1 : cin;
            idx_next   = '0;
            state_next = RUN;
          end else begin
            state_next = IDLE;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule
